// File: rtl/oled_pkg.sv
// Shared definitions for the OLED frame streamer: FSM state encoding,
// SSD1331-style window command bytes, and the colour-bar palette used by the
// optional test pattern (enabled by defining OLED_TESTPAT_EN).
package oled_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_FETCH = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] CMD_SET_COL   = 8'h15;
  localparam logic [7:0] CMD_SET_ROW   = 8'h75;
  localparam int         NUM_CMD_BYTES = 6;

  // Eight vertical bars, 12 columns each at the default 96-column width.
  localparam logic [15:0] BAR_COLOURS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  // Command byte sequence: set column window 0..col_end, set row window 0..row_end.
  function automatic logic [7:0] cmd_byte(input logic [2:0] ptr,
                                          input logic [7:0] col_end,
                                          input logic [7:0] row_end);
    case (ptr)
      3'd0:    cmd_byte = CMD_SET_COL;
      3'd1:    cmd_byte = 8'h00;
      3'd2:    cmd_byte = col_end;
      3'd3:    cmd_byte = CMD_SET_ROW;
      3'd4:    cmd_byte = 8'h00;
      default: cmd_byte = row_end;
    endcase
  endfunction

  // Bar colour for a column; columns past the eighth bar stay on the last colour.
  function automatic logic [15:0] bar_colour(input logic [12:0] col);
    logic [12:0] bar;
    bar = col / 13'd12;
    if (bar > 13'd7) bar = 13'd7;
    return BAR_COLOURS[bar[2:0]];
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI shifter: generates sclk (idle high) and shifts an 8- or 16-bit word
// MSB first. A load falls sclk and presents the MSB on the same clk; sclk rises
// CLK_DIV clks later and each bit lasts 2*CLK_DIV clks. done is a combinational
// strobe during the final clk of the last bit, so a load issued in response
// starts the next word with no gap.
module spi_byte_shifter
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        len16,
  input  logic [15:0] word,
  output logic        sclk,
  output logic        sdin,
  output logic        done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic        active;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;   // bits still to send after the current one
  logic [14:0] shreg;
  logic        half_end;

  assign half_end = active && (div_cnt == DIV_LAST);
  assign done     = half_end && sclk && (bit_cnt == 4'd0);

  // sclk divider and MSB-first shift; load wins over the end of the current word.
  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      div_cnt <= 8'd0;
      bit_cnt <= 4'd0;
      shreg   <= 15'd0;
      sclk    <= 1'b1;
      sdin    <= 1'b0;
    end else if (load) begin
      active  <= 1'b1;
      div_cnt <= 8'd0;
      bit_cnt <= len16 ? 4'd15 : 4'd7;
      shreg   <= word[14:0];
      sclk    <= 1'b0;
      sdin    <= word[15];
    end else if (half_end) begin
      div_cnt <= 8'd0;
      if (!sclk) begin
        sclk <= 1'b1;
      end else if (bit_cnt != 4'd0) begin
        sclk    <= 1'b0;
        sdin    <= shreg[14];
        shreg   <= {shreg[13:0], 1'b0};
        bit_cnt <= bit_cnt - 4'd1;
      end else begin
        active <= 1'b0;
      end
    end else if (active) begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/oled_frame_streamer.sv
// Streams one full RGB565 frame to an SPI OLED: six window command bytes,
// then WIDTH*HEIGHT pixels fetched from a registered pixel source.
// Define OLED_TESTPAT_EN to add a test_en input that substitutes colour bars.
// Handshake: start is sampled only in IDLE; it is ignored (not queued) while
// busy. pixel_index is held two clks before each pixel word is latched, since
// pixel_data follows pixel_index with one clk of latency.
module oled_frame_streamer
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef OLED_TESTPAT_EN
  input  logic        test_en,
`endif
  output logic [12:0] pixel_index,
  input  logic [15:0] pixel_data,
  output logic        cs,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  state_dbg
);

  localparam logic [12:0] LAST_PIX = 13'(WIDTH * HEIGHT - 1);
  localparam logic [2:0]  LAST_CMD = 3'(NUM_CMD_BYTES - 1);
  localparam logic [7:0]  COL_END  = 8'(WIDTH - 1);
  localparam logic [7:0]  ROW_END  = 8'(HEIGHT - 1);

  state_t      state;
  logic [2:0]  byte_ptr;
  logic        fetch_cnt;
  logic        sh_load;
  logic        sh_len16;
  logic        sh_done;
  logic [15:0] sh_word;
  logic [15:0] pix_word;

  assign state_dbg = state;

`ifdef OLED_TESTPAT_EN
  logic [12:0] col;

  // Column tracker for the colour bars; follows pixel_index row by row.
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= 13'd0;
    end else if (state == ST_CMD && sh_done && byte_ptr == LAST_CMD) begin
      col <= 13'd0;
    end else if (state == ST_SHIFT && sh_done && pixel_index != LAST_PIX) begin
      col <= (col == 13'(WIDTH - 1)) ? 13'd0 : col + 13'd1;
    end
  end

  assign pix_word = test_en ? bar_colour(col) : pixel_data;
`else
  assign pix_word = pixel_data;
`endif

  // Shifter load requests: first command byte on start, chained command bytes, pixel words.
  always_comb begin
    sh_load  = 1'b0;
    sh_len16 = 1'b0;
    sh_word  = 16'h0000;
    case (state)
      ST_IDLE: begin
        if (start) begin
          sh_load = 1'b1;
          sh_word = {cmd_byte(3'd0, COL_END, ROW_END), 8'h00};
        end
      end
      ST_CMD: begin
        if (sh_done && byte_ptr != LAST_CMD) begin
          sh_load = 1'b1;
          sh_word = {cmd_byte(byte_ptr + 3'd1, COL_END, ROW_END), 8'h00};
        end
      end
      ST_FETCH: begin
        if (fetch_cnt) begin
          sh_load  = 1'b1;
          sh_len16 = 1'b1;
          sh_word  = pix_word;
        end
      end
      default: ;
    endcase
  end

  // Frame sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cs          <= 1'b1;
      d_cn        <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      pixel_index <= 13'd0;
      byte_ptr    <= 3'd0;
      fetch_cnt   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_CMD;
            cs       <= 1'b0;
            busy     <= 1'b1;
            d_cn     <= 1'b0;
            byte_ptr <= 3'd0;
          end
        end
        ST_CMD: begin
          if (sh_done) begin
            if (byte_ptr == LAST_CMD) begin
              state       <= ST_FETCH;
              pixel_index <= 13'd0;
              fetch_cnt   <= 1'b0;
            end else begin
              byte_ptr <= byte_ptr + 3'd1;
            end
          end
        end
        ST_FETCH: begin
          if (fetch_cnt) begin
            state     <= ST_SHIFT;
            d_cn      <= 1'b1;
            fetch_cnt <= 1'b0;
          end else begin
            fetch_cnt <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (sh_done) begin
            if (pixel_index == LAST_PIX) begin
              state      <= ST_DONE;
              cs         <= 1'b1;
              frame_done <= 1'b1;
            end else begin
              state       <= ST_FETCH;
              pixel_index <= pixel_index + 13'd1;
            end
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          frame_done <= 1'b0;
          busy       <= 1'b0;
          d_cn       <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .len16 (sh_len16),
    .word  (sh_word),
    .sclk  (sclk),
    .sdin  (sdin),
    .done  (sh_done)
  );

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Bench for oled_frame_streamer. Instance A uses the default geometry and
// CLK_DIV=4 for command bytes, the first 100 pixels, reset abort and (with
// OLED_TESTPAT_EN) the colour bars. Instance B uses a reduced 16x4 panel at
// CLK_DIV=1 so that complete frames, restart suppression and back-to-back
// frames fit in a short run.
module tb_oled_frame_streamer;
  import oled_pkg::*;

  localparam int B_DIV = 1;
  localparam int B_W   = 16;
  localparam int B_H   = 4;
  localparam int B_N   = B_W * B_H;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, start_a, reset_b, start_b;
  logic [12:0] pixel_index_a, pixel_index_b;
  logic [15:0] pixel_data_a, pixel_data_b;
  logic cs_a, sclk_a, sdin_a, d_cn_a, busy_a, frame_done_a;
  logic cs_b, sclk_b, sdin_b, d_cn_b, busy_b, frame_done_b;
  logic [2:0] state_dbg_a, state_dbg_b;
`ifdef OLED_TESTPAT_EN
  logic test_en_a, test_en_b;
`endif

  oled_frame_streamer dut_a (
    .clk(clk), .reset(reset_a), .start(start_a),
`ifdef OLED_TESTPAT_EN
    .test_en(test_en_a),
`endif
    .pixel_index(pixel_index_a), .pixel_data(pixel_data_a),
    .cs(cs_a), .sclk(sclk_a), .sdin(sdin_a), .d_cn(d_cn_a),
    .busy(busy_a), .frame_done(frame_done_a), .state_dbg(state_dbg_a)
  );

  oled_frame_streamer #(.CLK_DIV(B_DIV), .WIDTH(B_W), .HEIGHT(B_H)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b),
`ifdef OLED_TESTPAT_EN
    .test_en(test_en_b),
`endif
    .pixel_index(pixel_index_b), .pixel_data(pixel_data_b),
    .cs(cs_b), .sclk(sclk_b), .sdin(sdin_b), .d_cn(d_cn_b),
    .busy(busy_b), .frame_done(frame_done_b), .state_dbg(state_dbg_b)
  );

  // ---------------- pixel sources (registered lookup) ----------------
  logic [15:0] mem_b [B_N];

  always @(posedge clk) begin
    pixel_data_a <= (pixel_index_a < 13'd96) ? 16'hFFFF : 16'h0000;
    pixel_data_b <= (pixel_index_b < 13'(B_N)) ? mem_b[pixel_index_b[5:0]] : 16'hDEAD;
  end

  // ---------------- SPI monitors ----------------
  logic [7:0]  cmd_qa[$], cmd_qb[$];
  logic [15:0] word_qa[$], word_qb[$];
  logic [15:0] sh_a, sh_b;
  int nb_a = 0, nb_b = 0;
  int fd_a = 0, fd_b = 0, cs_low_b = 0, max_idx_b = 0;
  logic sclk_prev_a = 1'b1, sclk_prev_b = 1'b1;

  always @(negedge clk) begin
    if (reset_a || cs_a) begin
      nb_a = 0;
    end else if (sclk_a && !sclk_prev_a) begin
      sh_a = {sh_a[14:0], sdin_a};
      nb_a++;
      if (!d_cn_a && nb_a == 8) begin cmd_qa.push_back(sh_a[7:0]); nb_a = 0; end
      else if (d_cn_a && nb_a == 16) begin word_qa.push_back(sh_a); nb_a = 0; end
    end
    if (frame_done_a) fd_a++;
    sclk_prev_a = sclk_a;
  end

  always @(negedge clk) begin
    if (reset_b || cs_b) begin
      nb_b = 0;
    end else if (sclk_b && !sclk_prev_b) begin
      sh_b = {sh_b[14:0], sdin_b};
      nb_b++;
      if (!d_cn_b && nb_b == 8) begin cmd_qb.push_back(sh_b[7:0]); nb_b = 0; end
      else if (d_cn_b && nb_b == 16) begin word_qb.push_back(sh_b); nb_b = 0; end
    end
    if (!cs_b) cs_low_b++;
    if (frame_done_b) fd_b++;
    if (int'(pixel_index_b) > max_idx_b) max_idx_b = int'(pixel_index_b);
    sclk_prev_b = sclk_b;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [7:0]  exp_cmd[$];
  logic [7:0]  got_cmd[$];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic score_words(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic score_cmd(input string tag);
    check({tag, "_count"}, got_cmd.size(), exp_cmd.size());
    for (int i = 0; i < exp_cmd.size() && i < got_cmd.size(); i++)
      check($sformatf("%s_b%0d", tag, i), got_cmd[i], exp_cmd[i]);
  endtask

  // Reference: clks from the first sclk fall to the frame end.
  function automatic int frame_clks(input int div, input int n);
    return (6 * 8 + n * 16) * 2 * div + n * 2;
  endfunction

  function automatic void build_cmd(input int w, input int h);
    exp_cmd = '{8'h15, 8'h00, 8'(w - 1), 8'h75, 8'h00, 8'(h - 1)};
  endfunction

  function automatic void randomize_mem();
    for (int i = 0; i < B_N; i++) mem_b[i] = 16'($urandom);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    reset_a = 1'b1; start_a = 1'b0; reset_b = 1'b1; start_b = 1'b0;
`ifdef OLED_TESTPAT_EN
    test_en_a = 1'b0; test_en_b = 1'b0;
`endif
    randomize_mem();
    repeat (3) tick();
    reset_a = 1'b0; reset_b = 1'b0;
    tick();

    // Reset state
    check("rst_cs", cs_a, 1'b1);
    check("rst_sclk", sclk_a, 1'b1);
    check("rst_sdin", sdin_a, 1'b0);
    check("rst_dcn", d_cn_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_fdone", frame_done_a, 1'b0);
    check("rst_pidx", pixel_index_a, 13'd0);
    check("rst_state", state_dbg_a, ST_IDLE);
    check("rst_cs_b", cs_b, 1'b1);

    // A: start pulse, cs falls next clk with the first bit presented
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("start_cs", cs_a, 1'b0);
    check("start_busy", busy_a, 1'b1);
    check("start_sclk", sclk_a, 1'b0);
    check("start_dcn", d_cn_a, 1'b0);

    for (int k = 0; k < 2000 && cmd_qa.size() < 6; k++) tick();
    build_cmd(96, 64);
    got_cmd = cmd_qa;
    score_cmd("a_cmd");

    // A: first 100 pixels (white first row, black afterwards), then reset
    for (int k = 0; k < 20000 && pixel_index_a != 13'd100; k++) tick();
    check("a_reach100", pixel_index_a, 13'd100);
    exp_q.delete();
    for (int i = 0; i < 100; i++) exp_q.push_back(i < 96 ? 16'hFFFF : 16'h0000);
    got_q = word_qa;
    score_words("a_pix");

    fd_a = 0;
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    check("abort_cs", cs_a, 1'b1);
    check("abort_sclk", sclk_a, 1'b1);
    check("abort_fdone", frame_done_a, 1'b0);
    check("abort_busy", busy_a, 1'b0);
    check("abort_pidx", pixel_index_a, 13'd0);
    repeat (300) tick();
    check("abort_no_fdone", fd_a, 0);
    check("abort_idle_cs", cs_a, 1'b1);

    cmd_qa.delete();
    repeat ($urandom_range(1, 5)) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 500 && cmd_qa.size() < 1; k++) tick();
    check("resume_cnt", cmd_qa.size() >= 1, 1'b1);
    if (cmd_qa.size() >= 1) check("resume_b0", cmd_qa[0], 8'h15);
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;

`ifdef OLED_TESTPAT_EN
    // A: colour bars replace pixel_data
    test_en_a = 1'b1;
    word_qa.delete();
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 20000 && word_qa.size() < 96; k++) tick();
    begin
      logic [15:0] bars [8];
      bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
      exp_q.delete();
      for (int i = 0; i < 96; i++) exp_q.push_back(bars[i / 12]);
    end
    got_q = word_qa;
    while (got_q.size() > 96) void'(got_q.pop_back());
    score_words("bar");
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    test_en_a = 1'b0;
`endif

    // B: one full frame with random pixel data
    cmd_qb.delete(); word_qb.delete(); fd_b = 0; cs_low_b = 0; max_idx_b = 0;
    repeat ($urandom_range(1, 5)) tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 6000 && fd_b < 1; k++) tick();
    check("b1_fdone", fd_b, 1);
    check("b1_cslen", cs_low_b, frame_clks(B_DIV, B_N));
    check("b1_maxidx", max_idx_b, B_N - 1);
    build_cmd(B_W, B_H);
    got_cmd = cmd_qb;
    score_cmd("b1_cmd");
    exp_q.delete();
    for (int i = 0; i < B_N; i++) exp_q.push_back(mem_b[i]);
    got_q = word_qb;
    score_words("b1_pix");
    repeat (5) tick();
    check("b1_busy_after", busy_b, 1'b0);
    check("b1_cs_after", cs_b, 1'b1);

    // B: start during a frame must neither restart nor queue
    randomize_mem();
    cmd_qb.delete(); word_qb.delete(); fd_b = 0; cs_low_b = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 3000 && pixel_index_b != 13'd30; k++) tick();
    check("b2_reach30", pixel_index_b, 13'd30);
    start_b = 1'b1;
    repeat (3) tick();
    start_b = 1'b0;
    check("b2_busy", busy_b, 1'b1);
    for (int k = 0; k < 200 && pixel_index_b == 13'd30; k++) tick();
    check("b2_next_idx", pixel_index_b, 13'd31);
    for (int k = 0; k < 6000 && fd_b < 1; k++) tick();
    repeat (50) tick();
    check("b2_fdone", fd_b, 1);
    check("b2_cslen", cs_low_b, frame_clks(B_DIV, B_N));
    got_cmd = cmd_qb;
    score_cmd("b2_cmd");
    exp_q.delete();
    for (int i = 0; i < B_N; i++) exp_q.push_back(mem_b[i]);
    got_q = word_qb;
    score_words("b2_pix");

    // B: start held high gives back-to-back frames
    randomize_mem();
    cmd_qb.delete(); word_qb.delete(); fd_b = 0; cs_low_b = 0;
    start_b = 1'b1;
    for (int k = 0; k < 6000 && fd_b < 1; k++) tick();
    repeat (3) tick();
    start_b = 1'b0;
    for (int k = 0; k < 6000 && fd_b < 2; k++) tick();
    repeat (20) tick();
    check("b3_fdone", fd_b, 2);
    check("b3_cslen", cs_low_b, 2 * frame_clks(B_DIV, B_N));
    check("b3_cmdcnt", cmd_qb.size(), 12);
    check("b3_busy_after", busy_b, 1'b0);
    exp_q.delete();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < B_N; i++) exp_q.push_back(mem_b[i]);
    got_q = word_qb;
    score_words("b3_pix");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
